// File: rtl/multi_gate_eval_pkg.sv
// Shared types for the multi-operand gate evaluator: gate codes, FSM states
// and the operand-count error codes reported on inp_num_err.
package multi_gate_eval_pkg;

    typedef enum logic [2:0] {
        GATE_AND     = 3'd0,
        GATE_OR      = 3'd1,
        GATE_NOT     = 3'd2,
        GATE_NAND    = 3'd3,
        GATE_NOR     = 3'd4,
        GATE_XOR     = 3'd5,
        GATE_XNOR    = 3'd6,
        GATE_ILLEGAL = 3'd7
    } gate_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_EVAL   = 3'd2,
        ST_RESULT = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    localparam logic [1:0] INP_ERR_NONE     = 2'b00;
    localparam logic [1:0] INP_ERR_TOO_MANY = 2'b01;
    localparam logic [1:0] INP_ERR_TOO_FEW  = 2'b10;
    localparam logic [1:0] INP_ERR_ILLEGAL  = 2'b11;

endpackage

// File: rtl/mge_reduce.sv
// Combinational bitwise reduction of operands 0..count-1 for the selected gate.
// Zero latency; no flow control (pure function of its inputs).
module mge_reduce
    import multi_gate_eval_pkg::*;
#(
    parameter int NUM_OPS = 4,
    parameter int WIDTH   = 8,
    localparam int CNT_W  = $clog2(NUM_OPS + 1)
) (
    input  gate_e                          gate,
    input  logic [CNT_W-1:0]               count,
    input  logic [NUM_OPS-1:0][WIDTH-1:0]  ops,
    output logic [WIDTH-1:0]               res
);

    logic [WIDTH-1:0] and_r;
    logic [WIDTH-1:0] or_r;
    logic [WIDTH-1:0] xor_r;

    // Slots at or beyond count may hold stale data from an earlier operation.
    always_comb begin
        and_r = '1;
        or_r  = '0;
        xor_r = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (CNT_W'(i) < count) begin
                and_r = and_r & ops[i];
                or_r  = or_r | ops[i];
                xor_r = xor_r ^ ops[i];
            end
        end
    end

    always_comb begin
        res = '0;
        case (gate)
            GATE_AND:  res = and_r;
            GATE_OR:   res = or_r;
            GATE_NOT:  res = ~ops[0];
            GATE_NAND: res = ~and_r;
            GATE_NOR:  res = ~or_r;
            GATE_XOR:  res = xor_r;
            GATE_XNOR: res = ~xor_r;
            default:   res = '0;
        endcase
    end

endmodule

// File: rtl/multi_gate_eval.sv
// Collects up to NUM_OPS operands, applies a bitwise gate; res_valid two cycles after op_last,
// held until res_ready. Optional saturating error counter under MULTI_GATE_EVAL_ERR_CNT_EN.
module multi_gate_eval
    import multi_gate_eval_pkg::*;
#(
    parameter int NUM_OPS = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       gate_type,
    input  logic [WIDTH-1:0] op_in,
    input  logic             op_valid,
    input  logic             op_last,
    input  logic             res_ready,
    input  logic             err_clr,
    output logic [WIDTH-1:0] res,
    output logic             res_valid,
    output logic             busy,
    output logic             time_lim_err,
    output logic [1:0]       inp_num_err,
    output logic [7:0]       err_cnt
);

    localparam int CNT_W = $clog2(NUM_OPS + 1);
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_OPS);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT - 1);

    state_e                         state_q, state_d;
    gate_e                          gate_q, gate_d;
    logic [CNT_W-1:0]               count_q, count_d;
    logic [TMR_W-1:0]               timer_q, timer_d;
    logic [NUM_OPS-1:0][WIDTH-1:0]  ops_q, ops_d;
    logic [WIDTH-1:0]               res_q, res_d;
    logic                           time_lim_err_q, time_lim_err_d;
    logic [1:0]                     inp_num_err_q, inp_num_err_d;
    logic [WIDTH-1:0]               red_res;

    mge_reduce #(
        .NUM_OPS (NUM_OPS),
        .WIDTH   (WIDTH)
    ) u_reduce (
        .gate  (gate_q),
        .count (count_q),
        .ops   (ops_q),
        .res   (red_res)
    );

    always_comb begin
        state_d        = state_q;
        gate_d         = gate_q;
        count_d        = count_q;
        timer_d        = timer_q;
        ops_d          = ops_q;
        res_d          = res_q;
        time_lim_err_d = time_lim_err_q;
        inp_num_err_d  = inp_num_err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    gate_d  = gate_e'(gate_type);
                    count_d = '0;
                    timer_d = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // An operand arriving on the last allowed idle cycle still counts.
                if (op_valid) begin
                    timer_d = '0;
                    if (count_q == CNT_MAX) begin
                        inp_num_err_d = INP_ERR_TOO_MANY;
                        state_d       = ST_ERROR;
                    end else begin
                        for (int i = 0; i < NUM_OPS; i++) begin
                            if (CNT_W'(i) == count_q) begin
                                ops_d[i] = op_in;
                            end
                        end
                        count_d = count_q + 1'b1;
                        if (op_last) begin
                            state_d = ST_EVAL;
                        end
                    end
                end else if (timer_q == TMR_MAX) begin
                    time_lim_err_d = 1'b1;
                    state_d        = ST_ERROR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_EVAL: begin
                if (gate_q == GATE_ILLEGAL) begin
                    inp_num_err_d = INP_ERR_ILLEGAL;
                    state_d       = ST_ERROR;
                end else if (gate_q == GATE_NOT && count_q != CNT_W'(1)) begin
                    inp_num_err_d = INP_ERR_TOO_MANY;
                    state_d       = ST_ERROR;
                end else if (gate_q != GATE_NOT && count_q < CNT_W'(2)) begin
                    inp_num_err_d = INP_ERR_TOO_FEW;
                    state_d       = ST_ERROR;
                end else begin
                    res_d   = red_res;
                    state_d = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (err_clr) begin
                    time_lim_err_d = 1'b0;
                    inp_num_err_d  = INP_ERR_NONE;
                    state_d        = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            gate_q         <= GATE_AND;
            count_q        <= '0;
            timer_q        <= '0;
            ops_q          <= '0;
            res_q          <= '0;
            time_lim_err_q <= 1'b0;
            inp_num_err_q  <= INP_ERR_NONE;
        end else begin
            state_q        <= state_d;
            gate_q         <= gate_d;
            count_q        <= count_d;
            timer_q        <= timer_d;
            ops_q          <= ops_d;
            res_q          <= res_d;
            time_lim_err_q <= time_lim_err_d;
            inp_num_err_q  <= inp_num_err_d;
        end
    end

`ifdef MULTI_GATE_EVAL_ERR_CNT_EN
    logic       err_entry;
    logic [7:0] err_cnt_q, err_cnt_d;

    // Counts error events, not error cycles; survives err_clr.
    always_comb begin
        err_entry = (state_d == ST_ERROR) && (state_q != ST_ERROR);
        err_cnt_d = err_cnt_q;
        if (err_entry && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

    assign res          = res_q;
    assign res_valid    = (state_q == ST_RESULT);
    assign busy         = (state_q != ST_IDLE);
    assign time_lim_err = time_lim_err_q;
    assign inp_num_err  = inp_num_err_q;

endmodule

// File: tb/tb_multi_gate_eval.sv
// Bench for multi_gate_eval: directed scenarios plus randomized operations against a reference model.
module tb_multi_gate_eval;

    localparam int NUM_OPS = 4;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [2:0]       gate_type;
    logic [WIDTH-1:0] op_in;
    logic             op_valid;
    logic             op_last;
    logic             res_ready;
    logic             err_clr;
    logic [WIDTH-1:0] res;
    logic             res_valid;
    logic             busy;
    logic             time_lim_err;
    logic [1:0]       inp_num_err;
    logic [7:0]       err_cnt;

    int total = 0;
    int bad = 0;
    int exp_err_cnt = 0;

    always #5 clk = ~clk;

    multi_gate_eval #(
        .NUM_OPS (NUM_OPS),
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .gate_type    (gate_type),
        .op_in        (op_in),
        .op_valid     (op_valid),
        .op_last      (op_last),
        .res_ready    (res_ready),
        .err_clr      (err_clr),
        .res          (res),
        .res_valid    (res_valid),
        .busy         (busy),
        .time_lim_err (time_lim_err),
        .inp_num_err  (inp_num_err),
        .err_cnt      (err_cnt)
    );

    // Reference: gate applied across the accepted operand list.
    function automatic logic [WIDTH-1:0] model_res(input int g, input logic [WIDTH-1:0] q[$]);
        logic [WIDTH-1:0] acc;
        acc = q[0];
        for (int i = 1; i < q.size(); i++) begin
            if (g == 0 || g == 3) acc = acc & q[i];
            else if (g == 1 || g == 4) acc = acc | q[i];
            else acc = acc ^ q[i];
        end
        if (g == 2) return ~q[0];
        if (g == 3 || g == 4 || g == 6) return ~acc;
        return acc;
    endfunction

    function automatic logic [1:0] model_err(input int g, input int n, input bit overflow);
        if (overflow) return 2'b01;
        if (g == 7) return 2'b11;
        if (g == 2 && n != 1) return 2'b01;
        if (g != 2 && n < 2) return 2'b10;
        return 2'b00;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic note_err();
`ifdef MULTI_GATE_EVAL_ERR_CNT_EN
        if (exp_err_cnt < 255) exp_err_cnt++;
`endif
    endtask

    task automatic start_op(input int g);
        gate_type = 3'(g);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_op(input logic [WIDTH-1:0] d, input logic last);
        op_in = d;
        op_valid = 1'b1;
        op_last = last;
        step();
        op_valid = 1'b0;
        op_last = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; gate_type = '0; op_in = '0;
        op_valid = 1'b0; op_last = 1'b0; res_ready = 1'b0; err_clr = 1'b0;
        #2;
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || res !== '0 || time_lim_err !== 1'b0
            || inp_num_err !== 2'b00 || err_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_state: busy=%b res_valid=%b res=%h tle=%b ine=%b err_cnt=%0d, want all zero",
                     busy, res_valid, res, time_lim_err, inp_num_err, err_cnt);
        end
        step(); step();
        reset = 1'b1;
        step();
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: busy=%b res_valid=%b, want 0 0", busy, res_valid);
        end
    endtask

    task automatic test_and_latency();
        start_op(0);
        send_op(8'hF0, 1'b0);
        send_op(8'hFF, 1'b0);
        send_op(8'h3C, 1'b1);
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL and_eval_cycle: res_valid=%b busy=%b, want 0 1", res_valid, busy);
        end
        step();
        total++;
        if (res_valid !== 1'b1 || res !== 8'h30) begin
            bad++;
            $display("FAIL and_result: res_valid=%b res=%h, want 1 30", res_valid, res);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || res !== 8'h30) begin
            bad++;
            $display("FAIL and_handoff: res_valid=%b busy=%b res=%h, want 0 0 30", res_valid, busy, res);
        end
    endtask

    task automatic test_xnor_hold();
        start_op(6);
        send_op(8'hAA, 1'b0);
        send_op(8'h0F, 1'b1);
        step();
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (res_valid !== 1'b1 || res !== 8'h5A) begin
                bad++;
                $display("FAIL xnor_hold[%0d]: res_valid=%b res=%h, want 1 5a", i, res_valid, res);
            end
            step();
        end
        start = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL xnor_release: res_valid=%b busy=%b, want 0 0", res_valid, busy);
        end
    endtask

    task automatic test_not_err();
        start_op(2);
        send_op(8'h11, 1'b0);
        send_op(8'h22, 1'b1);
        step();
        note_err();
        step(); step();
        total++;
        if (inp_num_err !== 2'b01 || busy !== 1'b1 || res_valid !== 1'b0 || err_cnt !== 8'(exp_err_cnt)) begin
            bad++;
            $display("FAIL not_err: ine=%b busy=%b res_valid=%b err_cnt=%0d, want 01 1 0 %0d",
                     inp_num_err, busy, res_valid, err_cnt, exp_err_cnt);
        end
        pulse_clr();
        total++;
        if (inp_num_err !== 2'b00 || time_lim_err !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL not_clr: ine=%b tle=%b busy=%b, want 00 0 0", inp_num_err, time_lim_err, busy);
        end
    endtask

    task automatic test_timeout();
        start_op(0);
        repeat (TIMEOUT - 1) step();
        total++;
        if (time_lim_err !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL timeout_early: tle=%b busy=%b, want 0 1", time_lim_err, busy);
        end
        step();
        note_err();
        total++;
        if (time_lim_err !== 1'b1 || inp_num_err !== 2'b00 || err_cnt !== 8'(exp_err_cnt)) begin
            bad++;
            $display("FAIL timeout_err: tle=%b ine=%b err_cnt=%0d, want 1 00 %0d",
                     time_lim_err, inp_num_err, err_cnt, exp_err_cnt);
        end
        pulse_clr();
        total++;
        if (time_lim_err !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_clr: tle=%b busy=%b, want 0 0", time_lim_err, busy);
        end
    endtask

    task automatic test_timeout_edge();
        start_op(1);
        repeat (TIMEOUT - 1) step();
        send_op(8'h0C, 1'b0);
        total++;
        if (time_lim_err !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL timeout_edge_op: tle=%b busy=%b, want 0 1", time_lim_err, busy);
        end
        repeat (TIMEOUT - 1) step();
        send_op(8'h30, 1'b1);
        step();
        total++;
        if (res_valid !== 1'b1 || res !== 8'h3C || time_lim_err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_edge_res: res_valid=%b res=%h tle=%b, want 1 3c 0", res_valid, res, time_lim_err);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_too_many();
        start_op(0);
        for (int i = 0; i <= NUM_OPS; i++) send_op(8'($urandom), 1'b0);
        note_err();
        total++;
        if (inp_num_err !== 2'b01 || busy !== 1'b1 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL too_many: ine=%b busy=%b res_valid=%b, want 01 1 0", inp_num_err, busy, res_valid);
        end
        pulse_clr();
    endtask

    task automatic test_illegal();
        start_op(7);
        send_op(8'h12, 1'b0);
        send_op(8'h34, 1'b1);
        step();
        note_err();
        total++;
        if (inp_num_err !== 2'b11) begin
            bad++;
            $display("FAIL illegal_gate: ine=%b, want 11", inp_num_err);
        end
        total++;
`ifdef MULTI_GATE_EVAL_ERR_CNT_EN
        if (err_cnt !== 8'd2) begin
            bad++;
            $display("FAIL err_cnt_two: err_cnt=%0d, want 2", err_cnt);
        end
`else
        if (err_cnt !== 8'd0) begin
            bad++;
            $display("FAIL err_cnt_off: err_cnt=%0d, want 0", err_cnt);
        end
`endif
        pulse_clr();
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int g;
            int n;
            bit overflow;
            logic [WIDTH-1:0] q[$];
            logic [WIDTH-1:0] d;
            logic [1:0] exp_e;
            logic [WIDTH-1:0] exp_r;
            g = int'($urandom_range(0, 7));
            n = int'($urandom_range(1, NUM_OPS + 1));
            overflow = (n == NUM_OPS + 1);
            q = {};
            repeat ($urandom_range(0, 2)) step();
            start_op(g);
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 3)) step();
                d = 8'($urandom);
                if (i < NUM_OPS) q.push_back(d);
                send_op(d, !overflow && i == n - 1);
            end
            if (!overflow) step();
            exp_e = model_err(g, n, overflow);
            if (exp_e != 2'b00) begin
                note_err();
                total++;
                if (inp_num_err !== exp_e || busy !== 1'b1 || res_valid !== 1'b0 || err_cnt !== 8'(exp_err_cnt)) begin
                    bad++;
                    $display("FAIL rand_err[%0d]: g=%0d n=%0d ine=%b busy=%b res_valid=%b err_cnt=%0d, want %b 1 0 %0d",
                             it, g, n, inp_num_err, busy, res_valid, err_cnt, exp_e, exp_err_cnt);
                end
                pulse_clr();
            end else begin
                exp_r = model_res(g, q);
                repeat ($urandom_range(0, 3)) step();
                total++;
                if (res_valid !== 1'b1 || res !== exp_r) begin
                    bad++;
                    $display("FAIL rand_res[%0d]: g=%0d n=%0d res_valid=%b res=%h, want 1 %h",
                             it, g, n, res_valid, res, exp_r);
                end
                res_ready = 1'b1;
                step();
                res_ready = 1'b0;
                total++;
                if (res_valid !== 1'b0 || busy !== 1'b0 || res !== exp_r) begin
                    bad++;
                    $display("FAIL rand_idle[%0d]: res_valid=%b busy=%b res=%h, want 0 0 %h",
                             it, res_valid, busy, res, exp_r);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        start_op(1);
        send_op(8'hA5, 1'b0);
        send_op(8'h5A, 1'b1);
        step();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        start_op(5);
        send_op(8'h55, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        exp_err_cnt = 0;
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || res !== '0 || time_lim_err !== 1'b0
            || inp_num_err !== 2'b00 || err_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_mid: busy=%b res_valid=%b res=%h tle=%b ine=%b err_cnt=%0d, want all zero",
                     busy, res_valid, res, time_lim_err, inp_num_err, err_cnt);
        end
        step();
        reset = 1'b1;
        step(); step();
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || res !== '0 || inp_num_err !== 2'b00) begin
            bad++;
            $display("FAIL reset_mid_after: busy=%b res_valid=%b res=%h ine=%b, want 0 0 00 00",
                     busy, res_valid, res, inp_num_err);
        end
        start_op(0);
        send_op(8'h0F, 1'b0);
        send_op(8'hFF, 1'b1);
        step();
        total++;
        if (res_valid !== 1'b1 || res !== 8'h0F) begin
            bad++;
            $display("FAIL reset_mid_recover: res_valid=%b res=%h, want 1 0f", res_valid, res);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_too_many();
        test_illegal();
        test_and_latency();
        test_xnor_hold();
        test_not_err();
        test_timeout();
        test_timeout_edge();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
